// File: rtl/pico_ctrl_core.sv
// PicoCtrl execution core: fetches from a combinational ROM and executes
// one conditional write/jump/halt instruction per enabled clock.
module pico_ctrl_core #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              en,
  input  logic [6:0]        cond_in,
  input  logic              resume,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [15:0]       rom_data,
  output logic [DATA_W-1:0] port0_out,
  output logic [DATA_W-1:0] port1_out,
  output logic [DATA_W-1:0] port2_out,
  output logic [DATA_W-1:0] port3_out,
  output logic [3:0]        port_we,
  output logic              retire,
  output logic              halted
);

  typedef enum logic {
    RUN  = 1'b0,
    HALT = 1'b1
  } state_e;

  localparam logic [1:0] ACT_NOP = 2'b00;
  localparam logic [1:0] ACT_WR  = 2'b01;
  localparam logic [1:0] ACT_JMP = 2'b10;
  localparam logic [1:0] ACT_HLT = 2'b11;

  state_e              state_q;
  logic [ADDR_W-1:0]   pc_q;
  logic [DATA_W-1:0]   port_q [4];
  logic [3:0]          port_we_q;
  logic                retire_q;
  logic                halted_q;
  logic [6:0]          sync1_q;
  logic [6:0]          sync2_q;

  logic [7:0]          cvec;
  logic [2:0]          cidx;
  logic                cexp;
  logic [1:0]          act;
  logic [1:0]          ridx;
  logic [DATA_W-1:0]   imm;
  logic                cond_ok;
  logic [ADDR_W-1:0]   pc_inc;
  logic [ADDR_W-1:0]   jmp_tgt;

  // c0 is a constant zero so that i=0,v=0 means "always"
  assign cvec    = {sync2_q, 1'b0};
  assign cidx    = rom_data[15:13];
  assign cexp    = rom_data[12];
  assign act     = rom_data[11:10];
  assign ridx    = rom_data[9:8];
  assign imm     = rom_data[DATA_W-1:0];
  assign cond_ok = (cvec[cidx] == cexp);
  assign pc_inc  = pc_q + ADDR_W'(1);
  assign jmp_tgt = rom_data[ADDR_W-1:0];

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= cond_in;
      sync2_q <= sync1_q;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= RUN;
      pc_q      <= '0;
      port_we_q <= '0;
      retire_q  <= 1'b0;
      halted_q  <= 1'b0;
      for (int k = 0; k < 4; k++) begin
        port_q[k] <= '0;
      end
    end else begin
      port_we_q <= '0;
      retire_q  <= 1'b0;
      unique case (state_q)
        RUN: begin
          if (en) begin
            retire_q <= 1'b1;
            pc_q     <= pc_inc;
            unique case (act)
              ACT_WR: begin
                if (cond_ok) begin
                  port_q[ridx] <= imm;
                  port_we_q    <= 4'b0001 << ridx;
                end
              end
              ACT_JMP: begin
                if (cond_ok) begin
                  pc_q <= jmp_tgt;
                end
              end
              ACT_HLT: begin
                if (cond_ok) begin
                  state_q  <= HALT;
                  halted_q <= 1'b1;
                end
              end
              ACT_NOP: ;
              default: ;
            endcase
          end
        end
        HALT: begin
          if (resume) begin
            state_q  <= RUN;
            halted_q <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign rom_addr  = pc_q;
  assign port0_out = port_q[0];
  assign port1_out = port_q[1];
  assign port2_out = port_q[2];
  assign port3_out = port_q[3];
  assign port_we   = port_we_q;
  assign retire    = retire_q;
  assign halted    = halted_q;

endmodule

// File: tb/tb_pico_ctrl_core.sv
// Testbench for pico_ctrl_core: directed program, single-word vector table,
// and randomized programs against a behavioural model.
module tb_pico_ctrl_core;

  logic        clk = 1'b0;
  logic        reset;
  logic        en;
  logic        resume;
  logic [6:0]  cond_in;
  logic [4:0]  rom_addr;
  logic [15:0] rom_data;
  logic [7:0]  p0, p1, p2, p3;
  logic [3:0]  port_we;
  logic        retire;
  logic        halted;

  logic [15:0] rom [32];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  assign rom_data = rom[rom_addr];

  pico_ctrl_core #(.ADDR_W(5), .DATA_W(8)) dut (
    .clk(clk),
    .reset(reset),
    .en(en),
    .cond_in(cond_in),
    .resume(resume),
    .rom_addr(rom_addr),
    .rom_data(rom_data),
    .port0_out(p0),
    .port1_out(p1),
    .port2_out(p2),
    .port3_out(p3),
    .port_we(port_we),
    .retire(retire),
    .halted(halted)
  );

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] port_val(input int r);
    case (r)
      0: return p0;
      1: return p1;
      2: return p2;
      default: return p3;
    endcase
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic rom_clear();
    for (int i = 0; i < 32; i++) rom[i] = 16'h0000;
  endtask

  // Behavioural reference: condition bits become visible two edges
  // after they are sampled, modelled as a two-deep FIFO of samples.
  int         m_pc;
  int         m_port [4];
  bit         m_halt;
  int         m_we;
  bit         m_ret;
  logic [6:0] m_pipe [$];

  task automatic model_step();
    logic [15:0] w;
    logic [6:0]  vis;
    int          i, act, r, imm;
    bit          c, ok;
    if (reset) begin
      m_pc = 0;
      m_halt = 0;
      m_we = 0;
      m_ret = 0;
      for (int k = 0; k < 4; k++) m_port[k] = 0;
      m_pipe = '{7'h0, 7'h0};
      return;
    end
    vis = m_pipe.pop_front();
    m_pipe.push_back(cond_in);
    m_we = 0;
    m_ret = 0;
    if (m_halt) begin
      if (resume) m_halt = 0;
    end else if (en) begin
      w = rom[m_pc];
      i = int'(w[15:13]);
      c = (i == 0) ? 1'b0 : vis[i-1];
      ok = (c == w[12]);
      act = int'(w[11:10]);
      r = int'(w[9:8]);
      imm = int'(w[7:0]);
      m_ret = 1;
      if (act == 2 && ok) m_pc = imm % 32;
      else m_pc = (m_pc + 1) % 32;
      if (act == 1 && ok) begin
        m_port[r] = imm;
        m_we = 1 << r;
      end
      if (act == 3 && ok) m_halt = 1;
    end
  endtask

  typedef struct {
    logic [15:0] word;
    logic [6:0]  cond;
    int          exp_pc;
    logic [3:0]  exp_we;
    int          exp_val;
    bit          exp_halt;
  } vec_t;

  vec_t vecs [10];

  initial begin
    vecs[0] = '{16'h0000, 7'h00, 1,  4'b0000, 8'h00, 1'b0};
    vecs[1] = '{16'h065A, 7'h00, 1,  4'b0100, 8'h5A, 1'b0};
    vecs[2] = '{16'h165A, 7'h7F, 1,  4'b0000, 8'h00, 1'b0};
    vecs[3] = '{16'hF4C3, 7'h40, 1,  4'b0001, 8'hC3, 1'b0};
    vecs[4] = '{16'hF4C3, 7'h3F, 1,  4'b0000, 8'h00, 1'b0};
    vecs[5] = '{16'h68FF, 7'h00, 31, 4'b0000, 8'h00, 1'b0};
    vecs[6] = '{16'h68FF, 7'h04, 1,  4'b0000, 8'h00, 1'b0};
    vecs[7] = '{16'h5C00, 7'h02, 1,  4'b0000, 8'h00, 1'b1};
    vecs[8] = '{16'h5C00, 7'h00, 1,  4'b0000, 8'h00, 1'b0};
    vecs[9] = '{16'h08E0, 7'h00, 0,  4'b0000, 8'h00, 1'b0};

    reset = 1'b1;
    en = 1'b0;
    resume = 1'b0;
    cond_in = 7'h01;

    // Directed program
    rom_clear();
    rom[0] = 16'h0501;
    rom[1] = 16'h3801;
    rom[2] = 16'h0C00;
    rom[3] = 16'h07AA;
    rom[7] = 16'h0C00;
    tick();
    tick();
    check("rst_addr", rom_addr, 0);
    check("rst_halted", halted, 0);
    check("rst_retire", retire, 0);
    check("rst_we", port_we, 0);
    check("rst_ports", {p0, p1, p2, p3}, 0);
    reset = 1'b0;
    tick();
    tick();
    en = 1'b1;
    tick();
    check("w0_port1", p1, 8'h01);
    check("w0_we", port_we, 4'b0010);
    check("w0_addr", rom_addr, 1);
    check("w0_retire", retire, 1);
    for (int k = 0; k < 3; k++) begin
      tick();
      check("jself_addr", rom_addr, 1);
      check("jself_retire", retire, 1);
      check("jself_we", port_we, 0);
    end
    cond_in = 7'h00;
    tick();
    check("sync_e1_addr", rom_addr, 1);
    tick();
    check("sync_e2_addr", rom_addr, 1);
    tick();
    check("sync_e3_addr", rom_addr, 2);
    tick();
    check("hlt_addr", rom_addr, 3);
    check("hlt_halted", halted, 1);
    check("hlt_retire", retire, 1);
    for (int k = 0; k < 10; k++) begin
      tick();
      check("hold_addr", rom_addr, 3);
      check("hold_halted", halted, 1);
      check("hold_retire", retire, 0);
    end
    resume = 1'b1;
    tick();
    resume = 1'b0;
    check("res_halted", halted, 0);
    check("res_addr", rom_addr, 3);
    check("res_retire", retire, 0);
    tick();
    check("w3_port3", p3, 8'hAA);
    check("w3_we", port_we, 4'b1000);
    check("w3_addr", rom_addr, 4);
    check("w3_retire", retire, 1);
    tick();
    tick();
    check("pre_en_addr", rom_addr, 6);
    en = 1'b0;
    for (int k = 0; k < 5; k++) begin
      tick();
      check("en0_addr", rom_addr, 6);
      check("en0_retire", retire, 0);
      check("en0_we", port_we, 0);
      check("en0_ports", {p1, p3}, 16'h01AA);
    end
    en = 1'b1;
    tick();
    check("reen_addr", rom_addr, 7);
    check("reen_retire", retire, 1);
    tick();
    check("hlt2_halted", halted, 1);
    check("hlt2_addr", rom_addr, 8);
    reset = 1'b1;
    resume = 1'b1;
    tick();
    check("rsth_addr", rom_addr, 0);
    check("rsth_halted", halted, 0);
    check("rsth_ports", {p0, p1, p2, p3}, 0);
    check("rsth_retire", retire, 0);
    reset = 1'b0;
    resume = 1'b0;

    // All-nop wrap
    rom_clear();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("wrap_start", rom_addr, 0);
    for (int k = 1; k <= 33; k++) begin
      tick();
      check("wrap_addr", rom_addr, k % 32);
    end

    // Single-instruction vector table
    for (int v = 0; v < 10; v++) begin
      rom_clear();
      rom[0] = vecs[v].word;
      reset = 1'b1;
      en = 1'b0;
      cond_in = vecs[v].cond;
      tick();
      tick();
      reset = 1'b0;
      tick();
      tick();
      en = 1'b1;
      tick();
      en = 1'b0;
      check($sformatf("vec%0d_pc", v), rom_addr, vecs[v].exp_pc);
      check($sformatf("vec%0d_we", v), port_we, vecs[v].exp_we);
      check($sformatf("vec%0d_val", v),
            port_val(int'(vecs[v].word[9:8])), vecs[v].exp_val);
      check($sformatf("vec%0d_halt", v), halted, vecs[v].exp_halt);
      check($sformatf("vec%0d_ret", v), retire, 1);
    end

    // Randomized programs against the model
    for (int i = 0; i < 32; i++) rom[i] = 16'($urandom);
    reset = 1'b1;
    en = 1'b0;
    resume = 1'b0;
    @(posedge clk);
    model_step();
    #1;
    for (int n = 0; n < 3000; n++) begin
      reset = ($urandom_range(0, 199) == 0);
      en = ($urandom_range(0, 3) != 0);
      resume = ($urandom_range(0, 5) == 0);
      if ($urandom_range(0, 5) == 0) cond_in = 7'($urandom);
      if ($urandom_range(0, 99) == 0) begin
        for (int i = 0; i < 32; i++) rom[i] = 16'($urandom);
      end
      @(posedge clk);
      model_step();
      #1;
      check("rnd_addr", rom_addr, m_pc);
      check("rnd_ports", {p0, p1, p2, p3},
            {m_port[0][7:0], m_port[1][7:0], m_port[2][7:0], m_port[3][7:0]});
      check("rnd_we", port_we, m_we);
      check("rnd_retire", retire, m_ret);
      check("rnd_halted", halted, m_halt);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
